sop_truth_table_scanner: RTL and testbench

//   Sequencer for the 4-input combinational SoP evaluator f(a,b,c,d).
//   On a start request it sweeps abcd through minterms 0..15, one index per slot.
//   It samples f for each index, builds the 16-bit minterm mask and counts the true minterms.
//   It compares the mask with an expected canonical mask.

---
 rtl/sop_truth_table_scanner_if.sv | 8 +
 rtl/sop_truth_table_scanner.sv | 82 ++++++++
 tb/tb_sop_truth_table_scanner.sv | 117 +++++++++++
 3 files changed

// File: rtl/sop_truth_table_scanner_if.sv
// sop_truth_table_scanner_if: start/f request side and sweep results of the truth-table scanner
interface sop_truth_table_scanner_if;
  logic start, f, a, b, c, d, busy, done, match;
  logic [15:0] mask;
  logic [4:0] count;
  modport master (output start, f, input a, b, c, d, busy, done, mask, count, match);
  modport slave (input start, f, output a, b, c, d, busy, done, mask, count, match);
endinterface

// File: rtl/sop_truth_table_scanner.sv
// sop_truth_table_scanner: sweeps abcd over 0..15, samples f into a minterm mask, counts ones, compares to EXPECTED_MASK
module sop_truth_table_scanner #(
  parameter logic [15:0] EXPECTED_MASK = 16'h7310,
  parameter int SETTLE = 0
) (
  input logic clk,
  input logic reset,
  sop_truth_table_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  localparam logic [3:0] SETTLE_W = 4'(SETTLE);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, wait_q, wait_d;
  logic [15:0] mask_q, mask_d;
  logic [4:0] count_q, count_d;
  logic busy_q, busy_d, done_q, done_d, match_q, match_d;
  // idx_q doubles as the abcd drive register; it is forced to 0 outside SWEEP
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      wait_q <= '0;
      mask_q <= '0;
      count_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wait_q <= wait_d;
      mask_q <= mask_d;
      count_q <= count_d;
      busy_q <= busy_d;
      done_q <= done_d;
      match_q <= match_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wait_d = wait_q;
    mask_d = mask_q;
    count_d = count_q;
    busy_d = busy_q;
    done_d = 1'b0;
    match_d = match_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SWEEP;
        idx_d = '0;
        wait_d = '0;
        mask_d = '0;
        count_d = '0;
        match_d = 1'b0;
        busy_d = 1'b1;
      end
      SWEEP: if (wait_q == SETTLE_W) begin
        mask_d[idx_q] = bus.f;
        count_d = count_q + {4'b0, bus.f};
        wait_d = '0;
        idx_d = (idx_q == 4'hF) ? 4'h0 : idx_q + 4'h1;
        if (idx_q == 4'hF) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
          match_d = (mask_d == EXPECTED_MASK);
        end
      end else begin
        wait_d = wait_q + 4'h1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign {bus.a, bus.b, bus.c, bus.d} = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.mask = mask_q;
  assign bus.count = count_q;
  assign bus.match = match_q;
endmodule

// File: tb/tb_sop_truth_table_scanner.sv
// tb_sop_truth_table_scanner: directed sweeps on SETTLE=0 and SETTLE=2 scanners with a result scoreboard
module tb_sop_truth_table_scanner;
  typedef struct packed {logic [15:0] m; logic [4:0] c; logic mt;} exp_t;
  logic clk, reset;
  logic [1:0] fmode;
  int checks, errors, edges, dc0, dc2;
  exp_t sb[$];
  sop_truth_table_scanner_if b0 ();
  sop_truth_table_scanner_if b2 ();
  sop_truth_table_scanner #(.EXPECTED_MASK(16'h7310), .SETTLE(0)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  sop_truth_table_scanner #(.EXPECTED_MASK(16'h7310), .SETTLE(2)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));
  function automatic logic sop(input logic a, b, c, d);
    return (a & ~c) | (b & ~c & ~d) | (a & b & ~d);
  endfunction
  assign b0.f = (fmode == 2'd0) ? sop(b0.a, b0.b, b0.c, b0.d) : (fmode == 2'd1);
  assign b2.f = (fmode == 2'd0) ? sop(b2.a, b2.b, b2.c, b2.d) : (fmode == 2'd1);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edges++;
  always @(negedge clk) begin
    if (b0.done) dc0++;
    if (b2.done) dc2++;
  end
  function automatic logic [3:0] abcd(input int s);
    return s == 0 ? {b0.a, b0.b, b0.c, b0.d} : {b2.a, b2.b, b2.c, b2.d};
  endfunction
  function automatic logic [23:0] res(input int s);
    return s == 0 ? {b0.mask, b0.count, b0.match, b0.busy, b0.done} : {b2.mask, b2.count, b2.match, b2.busy, b2.done};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic sweep(input int s, input logic [1:0] fm, input logic [15:0] em, input logic noise);
    int pe, n, lat;
    exp_t e;
    logic got;
    fmode = fm;
    e.m = em;
    e.c = 5'($countones(em));
    e.mt = (em == 16'h7310);
    sb.push_back(e);
    pe = edges;
    if (s == 0) b0.start = 1'b1; else b2.start = 1'b1;
    @(negedge clk);
    lat = 16 * (s + 1);
    got = 1'b0;
    for (int i = 0; i < lat + 8; i++) begin
      n = edges - pe - 1;
      if (res(s)[0]) begin
        got = 1'b1;
        break;
      end
      chk("abcd", 32'(abcd(s)), 32'(n / (s + 1)));
      chk("busy", 32'(res(s)[1]), 32'd1);
      b0.start = noise && (n == 2 || n == 3 || n == 9);
      b2.start = 1'b0;
      @(negedge clk);
    end
    b0.start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(edges - pe), 32'(lat + 1));
    e = sb.pop_front();
    chk("mask", 32'(res(s)[23:8]), 32'(e.m));
    chk("count", 32'(res(s)[7:3]), 32'(e.c));
    chk("match", 32'(res(s)[2]), 32'(e.mt));
    chk("busy_done", 32'(res(s)[1]), 32'd0);
    chk("abcd_done", 32'(abcd(s)), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(res(s)[0]), 32'd0);
    chk("hold_mask", 32'(res(s)[23:8]), 32'(e.m));
    chk("hold_count", 32'(res(s)[7:3]), 32'(e.c));
  endtask
  initial begin
    checks = 0; errors = 0; edges = 0; dc0 = 0; dc2 = 0;
    fmode = 2'd0; b0.start = 1'b0; b2.start = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out0", 32'(res(0)), 32'd0);
    chk("rst_out2", 32'(res(2)), 32'd0);
    chk("rst_abcd0", 32'(abcd(0)), 32'd0);
    chk("rst_abcd2", 32'(abcd(2)), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", 32'(dc0 + dc2), 32'd0);
    chk("idle_busy", 32'(res(0)[1]), 32'd0);
    sweep(0, 2'd0, 16'h7310, 1'b0);
    sweep(0, 2'd1, 16'hFFFF, 1'b0);
    sweep(0, 2'd2, 16'h0000, 1'b0);
    sweep(2, 2'd0, 16'h7310, 1'b0);
    // abort a sweep with reset once abcd reaches 7
    fmode = 2'd0;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    for (int i = 0; i < 40 && abcd(0) != 4'd7; i++) @(negedge clk);
    chk("reach_idx7", 32'(abcd(0)), 32'd7);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_out", 32'(res(0)), 32'd0);
    chk("abort_abcd", 32'(abcd(0)), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(res(0)), 32'd0);
    chk("abort_nodone", 32'(dc0), 32'd3);
    sweep(0, 2'd0, 16'h7310, 1'b1);
    repeat (20) @(negedge clk);
    chk("done_count0", 32'(dc0), 32'd4);
    chk("done_count2", 32'(dc2), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
